param_seq_detector: RTL and testbench

Serial-bit pattern detector. The pattern, its length and its overlap mode are programmable at run time. It is the generalised successor of the fixed 4-bit "1010" Moore detector. It emits a same-cycle (Mealy) match strobe and a registered (Moore) match flag, and it keeps a saturating match counter. It sits on serial control and status streams in front of the event and interrupt logic.

---
 rtl/param_seq_detector_pkg.sv | 27 ++
 rtl/param_seq_detector_sat_counter.sv | 27 ++
 rtl/param_seq_detector.sv | 97 +++++++++
 tb/tb_param_seq_detector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_seq_detector_pkg.sv
// Shared helpers for the programmable serial pattern detector:
// length clamping, compare-mask generation and overlap-mode encodings.
package seq_det_pkg;

  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

  localparam int MASK_W = 64;

  function automatic int clamp_len(input int len, input int max_len);
    int r;
    r = len;
    if (r < 1) r = 1;
    if (r > max_len) r = max_len;
    return r;
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/param_seq_detector_sat_counter.sv
// Saturating up-counter; clear wins over hold but a same-cycle increment
// still counts, so clear+inc leaves the count at one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Programmable serial pattern detector: run-time pattern/length/overlap,
// same-cycle match strobe, registered match flag and saturating match count.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN         = 8,
  parameter int                 COUNT_W         = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'h0A,
  parameter int                 DEFAULT_LEN     = 4,
  parameter logic               DEFAULT_OVERLAP = OVL_ON
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         x,
  input  logic                         in_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match_now,
  output logic                         match,
  output logic [COUNT_W-1:0]           match_count,
  output logic [$clog2(MAX_LEN+1)-1:0] busy_fill
);

  localparam int LW = $clog2(MAX_LEN+1);

  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      fill_q;
  logic [LW-1:0]      fill_d;
  logic               overlap_q;
  logic               match_q;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic [LW-1:0]      cfg_len_c;
  logic               fill_ok;
  logic               hit;

  always_comb begin
    mask      = MAX_LEN'(len_mask(int'(len_q)));
    // The incoming bit is the newest window bit, so a match needs only len-1 stored bits.
    window    = {hist_q[MAX_LEN-2:0], x};
    fill_ok   = (int'(fill_q) >= (int'(len_q) - 1));
    hit       = (((window ^ pattern_q) & mask) == '0);
    match_now = in_valid & ~cfg_load & ~rst & fill_ok & hit;
    cfg_len_c = LW'(clamp_len(int'(cfg_len), MAX_LEN));

    fill_d = fill_q;
    if (in_valid) begin
      if (match_now && (overlap_q == OVL_OFF)) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEFAULT_PATTERN;
      len_q     <= LW'(DEFAULT_LEN);
      overlap_q <= DEFAULT_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len_c;
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      if (in_valid) hist_q <= window;
      fill_q  <= fill_d;
      match_q <= match_now;
    end
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_now),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign match     = match_q;
  assign busy_fill = fill_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed plus random stimulus for param_seq_detector, checked against a
// queue-based model of "bits received since the last history restart".
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int COUNT_W = 3;
  localparam int LW      = 4;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst, x, in_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               match_now, match;
  logic [COUNT_W-1:0] match_count;
  logic [LW-1:0]      busy_fill;

  param_seq_detector #(
    .MAX_LEN         (MAX_LEN),
    .COUNT_W         (COUNT_W),
    .DEFAULT_PATTERN (8'h0A),
    .DEFAULT_LEN     (4),
    .DEFAULT_OVERLAP (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match_now   (match_now),
    .match       (match),
    .match_count (match_count),
    .busy_fill   (busy_fill)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: bits received since the last restart (reset, cfg_load or non-overlap match).
  bit       hq[$];
  int       m_len = 4;
  bit [7:0] m_pat = 8'h0A;
  bit       m_ovl = 1'b1;
  int       m_cnt = 0;
  bit       m_match = 1'b0;
  logic     obs_mn;

  function automatic bit model_mn();
    bit b;
    if (rst || cfg_load || !in_valid) return 1'b0;
    if (hq.size() + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? bit'(x) : hq[hq.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic xb, input logic ld,
                       input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic clr);
    bit mn;
    int l;
    @(negedge clk);
    rst = r; in_valid = v; x = xb; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cnt_clr = clr;
    #1;
    mn = model_mn();
    obs_mn = match_now;
    chk("match_now", {31'd0, match_now}, {31'd0, mn});
    @(posedge clk);
    if (r) begin
      hq.delete(); m_len = 4; m_pat = 8'h0A; m_ovl = 1'b1; m_cnt = 0; m_match = 1'b0;
    end else begin
      if (clr) m_cnt = mn ? 1 : 0;
      else if (mn && m_cnt < CMAX) m_cnt++;
      if (ld) begin
        l = int'(len);
        if (l == 0) l = 1;
        if (l > MAX_LEN) l = MAX_LEN;
        m_len = l; m_pat = pat; m_ovl = ovl; hq.delete(); m_match = 1'b0;
      end else begin
        if (v) begin
          hq.push_back(xb);
          if (hq.size() > MAX_LEN) void'(hq.pop_front());
          if (mn && !m_ovl) hq.delete();
        end
        m_match = mn;
      end
    end
    #1;
    chk("match", {31'd0, match}, {31'd0, m_match});
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("busy_fill", 32'(busy_fill), 32'((hq.size() < m_len) ? hq.size() : m_len));
  endtask

  task automatic bitv(input logic xb);
    drive(1'b0, 1'b1, xb, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic clr_cnt();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    drive(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic send(input logic [7:0] s, input int n, output logic [7:0] hits);
    hits = '0;
    for (int i = 0; i < n; i++) begin
      bitv(s[n-1-i]);
      hits[i] = obs_mn;
    end
  endtask

  logic [7:0] hits;

  initial begin
    rst = 1'b1; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("reset_count", 32'(match_count), 32'd0);
    chk("reset_fill", 32'(busy_fill), 32'd0);

    // Default 1010 overlapping
    send(8'b1010_1010, 8, hits);
    chk("t1_hits", 32'(hits), 32'h0A8);
    chk("t1_count", 32'(match_count), 32'd3);

    // Non-overlapping
    clr_cnt();
    load(8'h0A, 4'd4, 1'b0);
    send(8'b1010_1010, 8, hits);
    chk("t2_hits", 32'(hits), 32'h088);
    chk("t2_count", 32'(match_count), 32'd2);

    // Gaps in in_valid keep a partial sequence
    load(8'h0A, 4'd4, 1'b1);
    clr_cnt();
    send(8'b101, 3, hits);
    idle(); idle(); idle();
    send(8'b0, 1, hits);
    chk("t3_hit", 32'(hits), 32'h01);
    chk("t3_count", 32'(match_count), 32'd1);

    // cfg_load beats a same-cycle valid bit
    send(8'b101, 3, hits);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 4'd8, 1'b1, 1'b0);
    chk("t4_fill0", 32'(busy_fill), 32'd0);
    send(8'hC3, 8, hits);
    chk("t4_hits", 32'(hits), 32'h080);

    // Length clamping
    load(8'h01, 4'd0, 1'b1);
    send(8'b101, 3, hits);
    chk("len0_hits", 32'(hits), 32'h05);
    load(8'hC3, 4'd12, 1'b1);
    send(8'hC3, 8, hits);
    chk("len12_hits", 32'(hits), 32'h080);
    chk("len12_fill", 32'(busy_fill), 32'd8);

    // Counter saturation, then clear with a simultaneous match
    load(8'h01, 4'd1, 1'b1);
    clr_cnt();
    for (int i = 0; i < 9; i++) bitv(1'b1);
    chk("sat_count", 32'(match_count), 32'(CMAX));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("clr_inc_count", 32'(match_count), 32'd1);

    // Reset mid-sequence restores defaults
    load(8'hFF, 4'd2, 1'b0);
    send(8'b101, 3, hits);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    send(8'b0, 1, hits);
    chk("rst_nomatch", 32'(hits), 32'h00);
    send(8'b1010, 4, hits);
    chk("rst_hits", 32'(hits), 32'h08);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, ld, clr, v, xb, ovl;
      logic [7:0] pat;
      logic [3:0] len;
      r   = ($urandom_range(0, 149) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      xb  = 1'($urandom);
      ovl = 1'($urandom);
      pat = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 4));
      drive(r, v, xb, ld, pat, len, ovl, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
